lbist_ora: RTL and testbench
============================

LBIST_ORA -- requirements
Module: lbist_ora

Interface
REQ-001 SHALL have parameter N_IN, default 267: width of the CUT response input.
REQ-002 SHALL have parameter N, default 24: MISR width; legal range 2..N_IN.
REQ-003 SHALL have parameter POLY, default 24'h00001B: feedback taps, bit i set = tap into stage i.
REQ-004 SHALL have parameter SEED, default 0: MISR value loaded on reset and on start.
REQ-005 SHALL have parameter NPAT, default 1024: number of patterns compacted per session, >=1.
REQ-006 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: begin a compaction session.
REQ-009 SHALL have port en, input, 1: din holds a valid response this cycle.
REQ-010 SHALL have port din, input, N_IN: CUT response vector.
REQ-011 SHALL have port golden, input, N: expected fault-free signature.
REQ-012 SHALL have port signature, output, N: current MISR contents.
REQ-013 SHALL have port pat_cnt, output, clog2(NPAT+1): responses compacted in the current session.
REQ-014 SHALL have ports busy, done, pass, each output, 1: session running, session complete, signature==golden.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 -> RUN next cycle; MISR<=SEED and pat_cnt<=0 on the same edge.
REQ-017 RUN: en=1 -> MISR updated and pat_cnt incremented on that edge; en=0 -> MISR and pat_cnt hold.
REQ-018 RUN: en=1 with pat_cnt==NPAT-1 -> final update, then DONE next cycle; en is ignored outside RUN.
REQ-019 Fold: f[i] = XOR of din[j] for all j with j mod N == i.
REQ-020 Update, Galois form: s'[0]=s[N-1]^f[0]; s'[i]=s[i-1]^(POLY[i]&s[N-1])^f[i] for i=1..N-1.
REQ-021 start during RUN SHALL be ignored; start in DONE restarts as from IDLE (MISR<=SEED, pat_cnt<=0, to RUN).
REQ-022 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-023 pass SHALL be registered, updated on the RUN->DONE edge, and held through DONE; pass=0 in IDLE and RUN.
REQ-024 signature and pat_cnt SHALL hold their final values in DONE until restart or reset.
REQ-025 pat_cnt SHALL never exceed NPAT.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, MISR=SEED, pat_cnt=0, busy=0, done=0, pass=0, from any state including mid-RUN.
REQ-027 rst SHALL have priority over start and en in the same cycle.

Configuration
REQ-028 Macro LBIST_ORA_MASK_EN defined: adds input port din_mask[N_IN-1:0]; din bits with mask=1 are forced to 0 before folding (X-masking).
REQ-029 Macro LBIST_ORA_MASK_EN undefined: no din_mask port; all din bits fold unmasked.

Verification
Use N=4, N_IN=8, POLY=4'b0011, SEED=0, NPAT=2 unless noted.
REQ-030 Bench: start, then din=8'h08 (en=1), then din=8'h00 (en=1) -> signature=4'b0011, done=1 next cycle; golden=4'h3 -> pass=1; golden=4'h2 -> pass=0.
REQ-031 Bench: start, then din=8'h01, then din=8'h00, with an en=0 cycle between them -> signature=4'b0010, pat_cnt=2; MISR holds during the en=0 cycle.
REQ-032 Bench: din=8'h88 twice (fold cancels) -> signature=4'h0; start pulsed mid-RUN -> ignored, pat_cnt continues.
REQ-033 Bench: rst=1 after first response -> next cycle IDLE, signature=0, pat_cnt=0, busy=0; start in DONE -> signature=SEED, pat_cnt=0, busy=1 next cycle.
REQ-034 Bench with LBIST_ORA_MASK_EN defined: din_mask=8'h08, din=8'h08 then 8'h00 -> signature=4'h0.

Source files
------------

// File: rtl/lbist_ora.sv
// ---------------------------------------------------------------------------
// lbist_ora - Logic BIST output response analyser.
//
// Compacts a stream of wide CUT response vectors into an N-bit Galois MISR.
// Each session runs for NPAT valid responses. At the end of the session the
// signature is compared against the golden value and the result is held.
//
// The response is spatially compacted into N bits before it enters the
// MISR: bit j of din is XORed into stage (j mod N).
//
// Parameters:
//   N_IN  - width of the CUT response input
//   N     - MISR width (2..N_IN)
//   POLY  - feedback taps, bit i set = MSB feeds back into stage i
//   SEED  - MISR value loaded on reset and at session start
//   NPAT  - number of responses compacted per session (>= 1)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin a session (accepted in IDLE and DONE)
//   en         - din carries a valid response this cycle (used in RUN only)
//   din        - CUT response vector
//   din_mask   - (LBIST_ORA_MASK_EN only) 1 = force that din bit to 0
//   golden     - expected fault-free signature
//   signature  - current MISR contents
//   pat_cnt    - responses compacted in the current session
//   busy       - session running
//   done       - session complete
//   pass       - signature matched golden at the end of the session
//
// Build option:
//   LBIST_ORA_MASK_EN - when defined, adds din_mask for X-masking.
// ---------------------------------------------------------------------------
module lbist_ora #(
    parameter int          N_IN = 267,
    parameter int          N    = 24,
    parameter logic [N-1:0] POLY = N'(24'h00001B),
    parameter logic [N-1:0] SEED = '0,
    parameter int          NPAT = 1024,
    localparam int         CW   = $clog2(NPAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            en,
    input  logic [N_IN-1:0] din,
`ifdef LBIST_ORA_MASK_EN
    input  logic [N_IN-1:0] din_mask,
`endif
    input  logic [N-1:0]    golden,
    output logic [N-1:0]    signature,
    output logic [CW-1:0]   pat_cnt,
    output logic            busy,
    output logic            done,
    output logic            pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(NPAT - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    misr_q, misr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d;

    logic [N_IN-1:0] dinEff;
    logic [N-1:0]    fold;
    logic [N-1:0]    misrNext;

    // Masked bits are forced to 0 so unknown CUT outputs cannot corrupt
    // the signature.
`ifdef LBIST_ORA_MASK_EN
    assign dinEff = din & ~din_mask;
`else
    assign dinEff = din;
`endif

    // Spatial compaction: bit j lands in stage j mod N.
    always_comb begin
        fold = '0;
        for (int j = 0; j < N_IN; j++) begin
            fold[j % N] = fold[j % N] ^ dinEff[j];
        end
    end

    // Galois MISR step. Stage 0 always receives the MSB, independent of
    // POLY[0]; the other stages take the MSB only where a tap is set.
    always_comb begin
        misrNext    = '0;
        misrNext[0] = misr_q[N-1] ^ fold[0];
        for (int i = 1; i < N; i++) begin
            misrNext[i] = misr_q[i-1] ^ (POLY[i] & misr_q[N-1]) ^ fold[i];
        end
    end

    // Next-state logic. Everything holds by default; start is honoured in
    // IDLE and DONE only, en is honoured in RUN only.
    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                pass_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    misr_d  = SEED;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                pass_d = 1'b0;
                if (en) begin
                    misr_d = misrNext;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        // The verdict is taken from the final signature on
                        // the same edge that enters DONE.
                        state_d = DONE;
                        pass_d  = (misrNext == golden);
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    misr_d  = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                misr_d  = SEED;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides start and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            misr_q  <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign signature = misr_q;
    assign pat_cnt   = cnt_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

endmodule

// File: tb/tb_lbist_ora.sv
// ---------------------------------------------------------------------------
// tb_lbist_ora - self-checking bench for lbist_ora (N=4, N_IN=8,
// POLY=4'b0011, SEED=0, NPAT=2).
//
// Every cycle the stimulus side drives inputs, advances a behavioural model
// of the analyser across the clock edge and pushes the expected outputs into
// a queue. An independent monitor pops one entry per cycle on the falling
// edge and compares it with what the DUT shows.
//
// Build option:
//   LBIST_ORA_MASK_EN - connects din_mask and runs the masking scenario.
// ---------------------------------------------------------------------------
module tb_lbist_ora;

    localparam int         N_IN = 8;
    localparam int         N    = 4;
    localparam logic [3:0] POLY = 4'b0011;
    localparam logic [3:0] SEED = 4'h0;
    localparam int         NPAT = 2;

    typedef struct {
        logic [3:0] sig;
        logic [1:0] cnt;
        logic       busy;
        logic       done;
        logic       pass;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dinMask = '0;
    logic [3:0] golden = '0;
    logic [3:0] signature;
    logic [1:0] patCnt;
    logic       busy;
    logic       done;
    logic       pass;

    expect_t expQ[$];
    int      nChecks = 0;
    int      nFails = 0;

    // Reference model state: mode 0 = idle, 1 = running, 2 = finished.
    int         mMode = 0;
    logic [3:0] mSig = SEED;
    int         mCnt = 0;
    logic       mPass = 1'b0;

    lbist_ora #(
        .N_IN(N_IN),
        .N(N),
        .POLY(POLY),
        .SEED(SEED),
        .NPAT(NPAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .en(en),
        .din(din),
`ifdef LBIST_ORA_MASK_EN
        .din_mask(dinMask),
`endif
        .golden(golden),
        .signature(signature),
        .pat_cnt(patCnt),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    always #5 clk = ~clk;

    // Signature after compacting one response: shift left, fold the
    // response in by bit position mod 4, and add the feedback polynomial
    // (stage 0 always taking the feedback) when the outgoing MSB is 1.
    function automatic logic [3:0] sigStep(input logic [3:0] s, input logic [7:0] d, input logic [7:0] m);
        int acc;
        int foldV;
        logic [7:0] dm;
        dm = d;
`ifdef LBIST_ORA_MASK_EN
        dm = d & ~m;
`else
        if (m != 8'h00) dm = d;
`endif
        foldV = 0;
        for (int j = 0; j < 8; j++) begin
            if (dm[j]) foldV = foldV ^ (1 << (j % 4));
        end
        acc = (int'(s) * 2) % 16;
        if (s[3]) acc = acc ^ int'(POLY | 4'b0001);
        acc = acc ^ foldV;
        return 4'(acc);
    endfunction

    // Advance the model across one rising edge.
    task automatic modelEdge(input logic r, input logic s, input logic e, input logic [7:0] d, input logic [3:0] g);
        if (r) begin
            mMode = 0; mSig = SEED; mCnt = 0; mPass = 1'b0;
        end else if (mMode == 1) begin
            if (e) begin
                mSig = sigStep(mSig, d, dinMask);
                mCnt = mCnt + 1;
                if (mCnt == NPAT) begin
                    mMode = 2;
                    mPass = (mSig == g);
                end
            end
        end else if (s) begin
            mMode = 1; mSig = SEED; mCnt = 0; mPass = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, step the model and queue the expectation.
    task automatic applyStimulus(input logic r, input logic s, input logic e, input logic [7:0] d, input logic [3:0] g);
        expect_t x;
        rst = r; start = s; en = e; din = d; golden = g;
        @(posedge clk);
        modelEdge(r, s, e, d, g);
        x.sig  = mSig;
        x.cnt  = 2'(mCnt);
        x.busy = (mMode == 1);
        x.done = (mMode == 2);
        x.pass = mPass;
        #1;
        expQ.push_back(x);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expectation is retired per cycle, away from the edge.
    always @(negedge clk) begin
        expect_t x;
        if (expQ.size() > 0) begin
            x = expQ.pop_front();
            checkOutput("signature", signature, x.sig);
            checkOutput("pat_cnt", {2'b00, patCnt}, {2'b00, x.cnt});
            checkOutput("busy", {3'b000, busy}, {3'b000, x.busy});
            checkOutput("done", {3'b000, done}, {3'b000, x.done});
            checkOutput("pass", {3'b000, pass}, {3'b000, x.pass});
        end
    end

    initial begin
        logic       r, s, e, wantPass;
        logic [7:0] d;
        logic [3:0] g;
        int         waitCycles;

        @(negedge clk);
        // Reset state.
        applyStimulus(1, 0, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 1, 8'hFF, 4'h0);

        // Basic session with matching golden, then a mismatching one.
        applyStimulus(0, 1, 0, 8'h00, 4'h3);
        applyStimulus(0, 0, 1, 8'h08, 4'h3);
        applyStimulus(0, 0, 1, 8'h00, 4'h3);
        applyStimulus(0, 0, 1, 8'h55, 4'h3);
        applyStimulus(0, 1, 0, 8'h00, 4'h2);
        applyStimulus(0, 0, 1, 8'h08, 4'h2);
        applyStimulus(0, 0, 1, 8'h00, 4'h2);
        applyStimulus(0, 0, 0, 8'h00, 4'h2);

        // en=0 gap between responses.
        applyStimulus(0, 1, 0, 8'h00, 4'h2);
        applyStimulus(0, 0, 1, 8'h01, 4'h2);
        applyStimulus(0, 0, 0, 8'hAA, 4'h2);
        applyStimulus(0, 0, 1, 8'h00, 4'h2);

        // Fold cancellation and start ignored mid-run.
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 1, 8'h88, 4'h0);
        applyStimulus(0, 1, 1, 8'h88, 4'h0);
        applyStimulus(0, 0, 0, 8'h00, 4'h0);

        // Reset mid-run, then a restart from DONE.
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 1, 8'h01, 4'h0);
        applyStimulus(1, 1, 1, 8'h01, 4'h0);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 1, 8'hC3, 4'h0);
        applyStimulus(0, 0, 1, 8'h3C, 4'h0);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 0, 8'h00, 4'h0);

`ifdef LBIST_ORA_MASK_EN
        // Masked bit must not reach the MISR.
        dinMask = 8'h08;
        applyStimulus(1, 0, 0, 8'h00, 4'h0);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 0, 1, 8'h08, 4'h0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        applyStimulus(0, 0, 0, 8'h00, 4'h0);
`endif

        // Randomized traffic; golden is sometimes set to the signature the
        // session is about to finish with so both verdicts are exercised.
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            g = 4'($urandom);
`ifdef LBIST_ORA_MASK_EN
            dinMask = 8'($urandom);
`endif
            wantPass = ($urandom_range(0, 1) == 1);
            if (wantPass && mMode == 1 && mCnt == NPAT - 1) g = sigStep(mSig, d, dinMask);
            applyStimulus(r, s, e, d, g);
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
